instruction_fetch: RTL



---
 rtl/rv32_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instruction_fetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 types for the fetch stage: PC/instruction entry and fetch FSM states.
// Pure declarations; no logic, no latency, no flow control.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between imem responses and decode; push visible at head next cycle.
// Flush beats push; push while full and pop while empty are ignored.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch: owns the PC, one outstanding imem read, buffered instructions to decode.
// Acked data reaches decode next cycle; requests stop while the buffer is full.
module instruction_fetch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misaligned_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] sq_addr_q, sq_addr_d;
  logic            err_q, err_d;
  logic            req_active, ack_hit;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count, count_after;
  fetch_entry_t    push_entry, head;
  logic [XLEN-1:0] redirect_tgt;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    sq_addr_d        = sq_addr_q;
    err_d            = err_q;
    req_active       = 1'b0;
    fifo_push        = 1'b0;
    redirect_tgt     = {redirect_pc[XLEN-1:2], 2'b00};
    fifo_pop         = !fifo_empty && instr_ready;
    count_after      = fifo_count + CW'(1) - CW'(fifo_pop);
    push_entry.pc    = fetch_pc_q;
    push_entry.instr = imem_rdata;

    // IDLE issues only with room, judged on the registered count.
    case (state_q)
      IDLE:        req_active = !fifo_full;
      REQ, SQUASH: req_active = 1'b1;
      default:     req_active = 1'b0;
    endcase
    ack_hit = req_active && imem_ack;

    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      err_d = 1'b1;
    end

    if (state_q == SQUASH) begin
      if (redirect_valid) begin
        fetch_pc_d = redirect_tgt;
      end
      if (ack_hit) begin
        state_d = REQ;
      end
    end else if (redirect_valid) begin
      // An unacked request stays on the bus at its old address until it drains.
      fetch_pc_d = redirect_tgt;
      sq_addr_d  = fetch_pc_q;
      state_d    = (req_active && !imem_ack) ? SQUASH : REQ;
    end else if (ack_hit) begin
      fifo_push  = 1'b1;
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      state_d    = (count_after < CW'(FIFO_DEPTH)) ? REQ : IDLE;
    end else if (req_active) begin
      state_d = REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      sq_addr_q  <= RESET_PC;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      sq_addr_q  <= sq_addr_d;
      err_q      <= err_d;
    end
  end

  assign imem_req       = req_active && !reset;
  assign imem_addr      = (state_q == SQUASH) ? sq_addr_q : fetch_pc_q;
  assign instr_valid    = !fifo_empty;
  assign instr_out      = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_out         = head.pc;
  assign misaligned_err = err_q;

endmodule
